// File: rtl/spi_slave_regbus.sv
// SPI frame decoder: command/address byte, then register bus writes or prefetched reads.
// Build option: define SPI_SLAVE_AUTOINC_EN for burst access with auto-incrementing reg_addr.
module spi_slave_regbus #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spi_start,
    input  logic              spi_sck_rising,
    input  logic              spi_sck_falling,
    input  logic              spi_busy,
    input  logic              mosi_in,
    input  logic [DATA_W-1:0] status,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata
);

`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_next;
    logic [DATA_W-1:0] rx_byte;
    logic              rw, rdata_pend;
    logic              do_start, do_abort, do_rise, do_fall, byte_done;

    // A restart wins over everything; losing busy ends the frame and masks strobes.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_abort   = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        if (spi_start) begin
            do_start   = 1'b1;
            state_next = CMD;
        end else if (state != IDLE) begin
            if (!spi_busy) begin
                do_abort   = 1'b1;
                state_next = IDLE;
            end else begin
                do_rise = spi_sck_rising;
                do_fall = spi_sck_falling;
                if (spi_sck_rising && (bit_cnt == LAST_BIT)) begin
                    state_next = DATA;
                end
            end
        end
    end

    assign byte_done = do_rise && (bit_cnt == LAST_BIT);
    assign rx_byte   = {rx_shift[DATA_W-2:0], mosi_in};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_next    <= '0;
            rw         <= 1'b0;
            rdata_pend <= 1'b0;
            miso       <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            rdata_pend <= reg_re;
            if (rdata_pend) begin
                tx_next <= reg_rdata;
            end
            if (AUTOINC && reg_we) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end

            if (do_start) begin
                bit_cnt    <= '0;
                rx_shift   <= '0;
                tx_shift   <= status;
                miso       <= status[DATA_W-1];
                tx_next    <= '0;
                rw         <= 1'b0;
                rdata_pend <= 1'b0;
            end else if (do_abort) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                if (do_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= byte_done ? '0 : bit_cnt + CNT_W'(1);
                    if (byte_done) begin
                        if (state == CMD) begin
                            rw       <= rx_byte[DATA_W-1];
                            reg_addr <= rx_byte[ADDR_W-1:0];
                            reg_re   <= rx_byte[DATA_W-1];
                        end else if (rw) begin
                            reg_re <= 1'b1;
                            if (AUTOINC) begin
                                reg_addr <= reg_addr + ADDR_W'(1);
                            end
                        end else begin
                            reg_wdata <= rx_byte;
                            reg_we    <= 1'b1;
                        end
                    end
                end
                // A zero count on a falling edge is a byte boundary only once past the command byte.
                if (do_fall) begin
                    if (bit_cnt != '0) begin
                        tx_shift <= tx_shift << 1;
                        miso     <= tx_shift[DATA_W-2];
                    end else if (state == DATA) begin
                        tx_shift <= tx_next;
                        miso     <= tx_next[DATA_W-1];
                        tx_next  <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regbus.sv
// Directed bench for spi_slave_regbus; expectations follow SPI_SLAVE_AUTOINC_EN when defined.
module tb_spi_slave_regbus;

`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       spi_start = 1'b0;
    logic       spi_sck_rising = 1'b0;
    logic       spi_sck_falling = 1'b0;
    logic       spi_busy = 1'b0;
    logic       mosi_in = 1'b0;
    logic [7:0] status = 8'h00;
    logic       miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [6:0] we_addr [64];
    logic [7:0] we_data [64];
    logic [6:0] re_addr [64];
    int         we_cnt = 0;
    int         re_cnt = 0;
    bit         overlap = 1'b0;
    logic [7:0] miso_rx [4];

    spi_slave_regbus #(.DATA_W(8), .ADDR_W(7)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .spi_start       (spi_start),
        .spi_sck_rising  (spi_sck_rising),
        .spi_sck_falling (spi_sck_falling),
        .spi_busy        (spi_busy),
        .mosi_in         (mosi_in),
        .status          (status),
        .miso            (miso),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_we          (reg_we),
        .reg_re          (reg_re),
        .reg_rdata       (reg_rdata)
    );

    always #5 clk = ~clk;

    // Register file stand-in: read data is address + 0x10, valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= {1'b0, reg_addr} + 8'h10;
    end

    always @(negedge clk) begin
        if (reg_we && reg_re) overlap = 1'b1;
        if (reg_we && we_cnt < 64) begin
            we_addr[we_cnt] = reg_addr;
            we_data[we_cnt] = reg_wdata;
            we_cnt++;
        end
        if (reg_re && re_cnt < 64) begin
            re_addr[re_cnt] = reg_addr;
            re_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One SPI bit: master samples miso on its rising edge, then the slave shifts on falling.
    task automatic spi_bit(input logic b, output logic m);
        mosi_in = b;
        m = miso;
        spi_sck_rising = 1'b1;
        tick(1);
        spi_sck_rising = 1'b0;
        tick(4);
        spi_sck_falling = 1'b1;
        tick(1);
        spi_sck_falling = 1'b0;
        tick(4);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic m;
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic frame_begin();
        spi_busy = 1'b1;
        spi_start = 1'b1;
        tick(1);
        spi_start = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        tick(4);
        spi_busy = 1'b0;
        tick(4);
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3,
                                 input int nfull, input int tail_bits);
        logic [7:0] bytes [4];
        logic [7:0] dummy;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        for (int i = 0; i < 4; i++) miso_rx[i] = 8'h00;
        frame_begin();
        for (int i = 0; i < nfull; i++) spi_byte(bytes[i], 8, miso_rx[i]);
        if (tail_bits > 0) spi_byte(bytes[nfull], tail_bits, dummy);
        frame_end();
    endtask

    initial begin
        int wb, rb;
        logic [7:0] dummy;

        tick(3);
        checkOutput("rst_miso", miso, 0);
        checkOutput("rst_we", reg_we, 0);
        checkOutput("rst_re", reg_re, 0);
        checkOutput("rst_addr", reg_addr, 0);
        checkOutput("rst_wdata", reg_wdata, 0);
        nrst = 1'b1;
        tick(3);

        // Burst write 0x05: A5, 3C
        status = 8'hC3;
        wb = we_cnt; rb = re_cnt;
        applyStimulus(8'h05, 8'hA5, 8'h3C, 8'h00, 3, 0);
        checkOutput("wr_we_count", we_cnt - wb, 2);
        checkOutput("wr_re_count", re_cnt - rb, 0);
        checkOutput("wr0_addr", we_addr[wb], 7'h05);
        checkOutput("wr0_data", we_data[wb], 8'hA5);
        checkOutput("wr1_addr", we_addr[wb+1], AUTOINC ? 7'h06 : 7'h05);
        checkOutput("wr1_data", we_data[wb+1], 8'h3C);
        checkOutput("wr_final_addr", reg_addr, AUTOINC ? 7'h07 : 7'h05);
        checkOutput("wr_miso_status", miso_rx[0], 8'hC3);
        checkOutput("wr_miso_data", miso_rx[1], 8'h00);
        checkOutput("wr_idle_miso", miso, 0);

        // Read 0x05 with status 0x5A
        status = 8'h5A;
        wb = we_cnt; rb = re_cnt;
        applyStimulus(8'h85, 8'h00, 8'h00, 8'h00, 3, 0);
        checkOutput("rd_miso0", miso_rx[0], 8'h5A);
        checkOutput("rd_miso1", miso_rx[1], 8'h15);
        checkOutput("rd_miso2", miso_rx[2], AUTOINC ? 8'h16 : 8'h15);
        checkOutput("rd_re_count", re_cnt - rb, 3);
        checkOutput("rd_we_count", we_cnt - wb, 0);
        checkOutput("rd_re0_addr", re_addr[rb], 7'h05);
        checkOutput("rd_re1_addr", re_addr[rb+1], AUTOINC ? 7'h06 : 7'h05);
        checkOutput("rd_re2_addr", re_addr[rb+2], AUTOINC ? 7'h07 : 7'h05);

        // Write across the address wrap
        wb = we_cnt;
        applyStimulus(8'h7F, 8'h11, 8'h22, 8'h00, 3, 0);
        checkOutput("wrap_we_count", we_cnt - wb, 2);
        checkOutput("wrap0_addr", we_addr[wb], 7'h7F);
        checkOutput("wrap0_data", we_data[wb], 8'h11);
        checkOutput("wrap1_addr", we_addr[wb+1], AUTOINC ? 7'h00 : 7'h7F);
        checkOutput("wrap1_data", we_data[wb+1], 8'h22);

        // Frame cut after 4 bits of the first data byte, then a clean frame
        wb = we_cnt; rb = re_cnt;
        applyStimulus(8'h10, 8'hF0, 8'h00, 8'h00, 1, 4);
        checkOutput("part_we_count", we_cnt - wb, 0);
        checkOutput("part_re_count", re_cnt - rb, 0);
        checkOutput("part_addr", reg_addr, 7'h10);
        wb = we_cnt;
        applyStimulus(8'h12, 8'h77, 8'h00, 8'h00, 2, 0);
        checkOutput("after_part_we_count", we_cnt - wb, 1);
        checkOutput("after_part_addr", we_addr[wb], 7'h12);
        checkOutput("after_part_data", we_data[wb], 8'h77);

        // Reset in the middle of a read data byte, then strobes without a start
        frame_begin();
        spi_byte(8'h85, 8, dummy);
        spi_byte(8'h00, 3, dummy);
        checkOutput("pre_rst_addr", reg_addr, 7'h05);
        checkOutput("pre_rst_miso", miso, 1);
        nrst = 1'b0;
        #1;
        wb = we_cnt; rb = re_cnt;
        checkOutput("midrst_miso", miso, 0);
        checkOutput("midrst_addr", reg_addr, 0);
        checkOutput("midrst_we", reg_we, 0);
        checkOutput("midrst_re", reg_re, 0);
        checkOutput("midrst_wdata", reg_wdata, 0);
        tick(2);
        nrst = 1'b1;
        tick(2);
        spi_byte(8'hFF, 8, dummy);
        checkOutput("idle_strobe_miso", dummy, 8'h00);
        frame_end();
        checkOutput("idle_strobe_we", we_cnt - wb, 0);
        checkOutput("idle_strobe_re", re_cnt - rb, 0);
        checkOutput("idle_strobe_addr", reg_addr, 0);

        // Read 0x03 with three data bytes
        rb = re_cnt;
        applyStimulus(8'h83, 8'h00, 8'h00, 8'h00, 4, 0);
        checkOutput("fifo_re_count", re_cnt - rb, 4);
        checkOutput("fifo_re0_addr", re_addr[rb], 7'h03);
        checkOutput("fifo_re1_addr", re_addr[rb+1], AUTOINC ? 7'h04 : 7'h03);
        checkOutput("fifo_re2_addr", re_addr[rb+2], AUTOINC ? 7'h05 : 7'h03);
        checkOutput("fifo_re3_addr", re_addr[rb+3], AUTOINC ? 7'h06 : 7'h03);
        checkOutput("fifo_miso0", miso_rx[0], 8'h5A);
        checkOutput("fifo_miso1", miso_rx[1], 8'h13);
        checkOutput("fifo_miso2", miso_rx[2], AUTOINC ? 8'h14 : 8'h13);
        checkOutput("fifo_miso3", miso_rx[3], AUTOINC ? 8'h15 : 8'h13);

        checkOutput("we_re_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
